blink_timer: RTL and testbench
==============================

# blink_timer

Duration timer that paces the blinking state machine. Consumes the machine's 3-bit count-enable vector and returns a one-cycle `o_ena` step pulse once the current ON or OFF phase has lasted its programmed number of ticks. A built-in prescaler sets the tick rate. The block sits directly upstream of the blinking state machine's `i_ena` input and downstream of its `o_count_ena` output.

## Interface
- `PRESCALE`, default 50000: clock cycles per tick; must be ≥ 1.
- `CNT_W`, default 16: width of duration inputs and phase counter.
- `i_clk`  in  1: clock, rising edge.
- `i_rst_n`  in  1: asynchronous, active-low reset.
- `i_count_ena`  in  3: phase select from the state machine.
  - Bit2 = run.
  - Bit1 = ON (1) / OFF (0).
  - Bit0 ignored.
- `i_on_ticks`  in  CNT_W: ON phase length in ticks.
- `i_off_ticks`  in  CNT_W: OFF phase length in ticks.
- `o_ena`  out  1: one-cycle pulse, phase complete.
- `o_busy`  out  1: high while a phase is being timed.

## Operation
- `prev_ena[2:1]` register holds the last sampled `i_count_ena[2:1]`.
  - A "change" is any edge where `i_count_ena[2:1] != prev_ena`.
- FSM states: IDLE, RUN, WAIT.
  - IDLE: bit2 = 0. Prescaler and phase counter held at 0.
  - RUN: timing a phase.
  - WAIT: pulse issued. Counting frozen until the next change.
- Transitions, evaluated every edge, in priority order:
  1. Bit2 = 0 → IDLE, from any state.
  2. Change with bit2 = 1 → RUN, from any state. Clear prescaler and phase counter. Latch target = bit1 ? `i_on_ticks` : `i_off_ticks`.
  3. RUN and the final tick is reached → WAIT, with `o_ena` ← 1.
- Target of 0 is treated as 1.
- Duration inputs are sampled only at phase start. Changing them mid-phase has no effect.
- Prescaler: counts 0..PRESCALE-1 and wraps. A tick is the edge where it equals PRESCALE-1.
- Phase counter (CNT_W bits): increments on each tick in RUN. The final tick is where phase+1 == target. The counter never wraps.
- Change during RUN (e.g. 110→100 before completion): restart with the new target. No `o_ena` for the abandoned phase.
- WAIT exists because the state machine updates `i_count_ena` two cycles after `o_ena`. No second pulse may occur in that window.
- `o_busy` = (state == RUN).

## Timing
- Reset values: `o_ena` = 0, `o_busy` = 0, state IDLE, `prev_ena` = 0, prescaler = 0, phase counter = 0, target = 0.
- Reset mid-phase aborts immediately. After release, behaviour is as from power-up.
- Let E0 be the edge that detects the change:
  - `o_ena` goes high after edge E0 + target·PRESCALE.
  - `o_ena` stays high exactly one cycle.
- `o_busy` rises after E0 and falls together with the rising edge of `o_ena`.
- Change and final tick on the same edge: the change wins. No pulse.
- Zero-latency path from `i_count_ena` to `o_ena` is forbidden. All outputs are registered.

## Configuration
- `BLINK_TIMER_PRESCALE_EN` defined: prescaler present. The phase counter advances once per PRESCALE cycles.
- Not defined: prescaler removed (no counter RTL). The phase counter advances every cycle, equivalent to PRESCALE = 1, for fast simulation. `o_ena` goes high target cycles after E0.

## Test plan
Common setup for all scenarios: PRESCALE = 4, macro defined, `i_on_ticks` = 3, `i_off_ticks` = 2.

- **ON phase:** reset, then `i_count_ena` 000→110 at E0 → `o_ena` high for one cycle after E0+12; `o_busy` high for E0+1..E0+12; then WAIT, no further pulse while 110 is held.
- **Full 3-blink sequence:** drive `i_count_ena` from the state machine model (110,100 ×3 then 000) → six `o_ena` pulses; ON gaps 12 cycles, OFF gaps 8 cycles (plus the 2-cycle state lag); IDLE afterwards with `o_ena` = 0.
- **Abandoned phase:** switch 110→100 at E0+5 → no pulse for the ON phase; pulse 8 cycles after the switch edge.
- **Zero target:** `i_off_ticks` = 0, enter 100 → `o_ena` after E0+4, same as target 1.
- **Mid-phase reset:** assert `i_rst_n` = 0 at E0+6 → `o_ena` and `o_busy` 0 immediately; hold 110 and release → new phase timed from release, pulse 12 cycles after the detecting edge.
- **Macro undefined:** `i_count_ena` 000→110 → pulse after E0+3.

Source files
------------

// File: rtl/blink_timer.sv
// Phase duration timer for the blinking state machine: times each ON/OFF phase
// and returns a one-cycle step pulse. Optional prescaler under BLINK_TIMER_PRESCALE_EN.
module blink_timer #(
  parameter int PRESCALE = 50000,
  parameter int CNT_W    = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [2:0]       i_count_ena,
  input  logic [CNT_W-1:0] i_on_ticks,
  input  logic [CNT_W-1:0] i_off_ticks,
  output logic             o_ena,
  output logic             o_busy,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [1:0]       prev_ena;
  logic [CNT_W-1:0] phase, phase_next, phase_inc;
  logic [CNT_W-1:0] target, target_next, sel_ticks;
  logic             ena_next;
  logic             change;
  logic             tick;
  logic             unused_bit0;

  assign unused_bit0 = i_count_ena[0];
  assign change      = (i_count_ena[2:1] != prev_ena);
  assign phase_inc   = phase + CNT_W'(1);
  assign sel_ticks   = i_count_ena[1] ? i_on_ticks : i_off_ticks;

`ifdef BLINK_TIMER_PRESCALE_EN
  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PS_W-1:0] presc, presc_next;

  assign tick = (state == RUN) && (presc == PS_W'(PRESCALE - 1));

  // Prescaler only runs while timing; a restart or IDLE clears it.
  always_comb begin
    presc_next = presc;
    if (!i_count_ena[2] || change) begin
      presc_next = '0;
    end else if (state == RUN) begin
      presc_next = tick ? '0 : presc + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      presc <= '0;
    end else begin
      presc <= presc_next;
    end
  end
`else
  localparam int unused_prescale = PRESCALE;

  assign tick = (state == RUN);
`endif

  always_comb begin
    state_next  = state;
    phase_next  = phase;
    target_next = target;
    ena_next    = 1'b0;
    if (!i_count_ena[2]) begin
      state_next = IDLE;
      phase_next = '0;
    end else if (change) begin
      // A change always restarts, even if the old phase finishes this edge.
      state_next  = RUN;
      phase_next  = '0;
      target_next = (sel_ticks == '0) ? CNT_W'(1) : sel_ticks;
    end else if (state == RUN && tick) begin
      if (phase_inc == target) begin
        state_next = WAIT;
        ena_next   = 1'b1;
      end else begin
        phase_next = phase_inc;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      prev_ena <= 2'b00;
      phase    <= '0;
      target   <= '0;
      o_ena    <= 1'b0;
    end else begin
      state    <= state_next;
      prev_ena <= i_count_ena[2:1];
      phase    <= phase_next;
      target   <= target_next;
      o_ena    <= ena_next;
    end
  end

  assign o_busy    = (state == RUN);
  assign dbg_state = state;

endmodule

// File: tb/tb_blink_timer.sv
// Directed bench for blink_timer; timing scales with the prescaler when
// BLINK_TIMER_PRESCALE_EN is defined (PRESCALE = 4), otherwise one tick per cycle.
module tb_blink_timer;

`ifdef BLINK_TIMER_PRESCALE_EN
  localparam int P = 4;
`else
  localparam int P = 1;
`endif
  localparam int T_ON  = 3 * P;
  localparam int T_OFF = 2 * P;

  logic        clk;
  logic        rst_n;
  logic [2:0]  count_ena;
  logic [15:0] on_ticks;
  logic [15:0] off_ticks;
  logic        ena;
  logic        busy;
  logic [1:0]  dbg_state;

  int checks;
  int errors;

  blink_timer #(.PRESCALE(4), .CNT_W(16)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_count_ena (count_ena),
    .i_on_ticks  (on_ticks),
    .i_off_ticks (off_ticks),
    .o_ena       (ena),
    .o_busy      (busy),
    .dbg_state   (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic go_idle();
    count_ena = 3'b000;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    count_ena = 3'b000;
    on_ticks  = 16'd3;
    off_ticks = 16'd2;
    repeat (3) @(negedge clk);
    checks++;
    if (ena !== 1'b0 || busy !== 1'b0 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL reset: ena=%b busy=%b state=%0d, want 0 0 0", ena, busy, dbg_state);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (ena !== 1'b0 || busy !== 1'b0 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL idle_after_reset: ena=%b busy=%b state=%0d, want 0 0 0", ena, busy, dbg_state);
    end
  endtask

  // ON phase; changing the duration mid-phase must not alter the length.
  task automatic test_on_phase();
    count_ena = 3'b110;
    for (int k = 0; k <= T_ON + 6; k++) begin
      @(negedge clk);
      if (k == 1) on_ticks = 16'd7;
      checks++;
      if (ena !== (k == T_ON) || busy !== (k < T_ON)) begin
        errors++;
        $display("FAIL on_phase k=%0d: ena=%b busy=%b, want %b %b", k, ena, busy, (k == T_ON), (k < T_ON));
      end
    end
    checks++;
    if (dbg_state !== 2'd2) begin
      errors++;
      $display("FAIL on_wait_state: state=%0d, want 2", dbg_state);
    end
    on_ticks = 16'd3;
    go_idle();
  endtask

  task automatic test_sequence();
    logic [2:0] seq [6];
    int         len;
    int         pulses;
    seq    = '{3'b110, 3'b100, 3'b110, 3'b100, 3'b110, 3'b100};
    pulses = 0;
    for (int p = 0; p < 6; p++) begin
      count_ena = seq[p];
      len = seq[p][1] ? T_ON : T_OFF;
      for (int k = 0; k <= len + 1; k++) begin
        @(negedge clk);
        if (ena === 1'b1) pulses++;
        checks++;
        if (ena !== (k == len)) begin
          errors++;
          $display("FAIL sequence p=%0d k=%0d: ena=%b, want %b", p, k, ena, (k == len));
        end
      end
    end
    count_ena = 3'b000;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (ena === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 6) begin
      errors++;
      $display("FAIL sequence_pulses: got %0d, want 6", pulses);
    end
    checks++;
    if (ena !== 1'b0 || busy !== 1'b0 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL sequence_idle: ena=%b busy=%b state=%0d, want 0 0 0", ena, busy, dbg_state);
    end
  endtask

  // Restart at switch index sw; when sw == T_ON the change and final tick coincide.
  task automatic test_abandon(input int sw, input string name);
    count_ena = 3'b110;
    for (int k = 0; k < sw; k++) begin
      @(negedge clk);
      if (k == sw - 1) count_ena = 3'b100;
      checks++;
      if (ena !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL %s pre k=%0d: ena=%b busy=%b, want 0 1", name, k, ena, busy);
      end
    end
    for (int j = 0; j <= T_OFF + 3; j++) begin
      @(negedge clk);
      checks++;
      if (ena !== (j == T_OFF) || busy !== (j < T_OFF)) begin
        errors++;
        $display("FAIL %s post j=%0d: ena=%b busy=%b, want %b %b", name, j, ena, busy, (j == T_OFF), (j < T_OFF));
      end
    end
    go_idle();
  endtask

  task automatic test_zero_target();
    off_ticks = 16'd0;
    count_ena = 3'b100;
    for (int k = 0; k <= P + 3; k++) begin
      @(negedge clk);
      checks++;
      if (ena !== (k == P)) begin
        errors++;
        $display("FAIL zero_target k=%0d: ena=%b, want %b", k, ena, (k == P));
      end
    end
    off_ticks = 16'd2;
    go_idle();
  endtask

  task automatic test_mid_reset();
    int rk;
    rk = (T_ON > 6) ? 6 : 2;
    count_ena = 3'b110;
    for (int k = 0; k < rk; k++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (ena !== 1'b0 || busy !== 1'b0 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL mid_reset: ena=%b busy=%b state=%0d, want 0 0 0", ena, busy, dbg_state);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k <= T_ON + 3; k++) begin
      @(negedge clk);
      checks++;
      if (ena !== (k == T_ON) || busy !== (k < T_ON)) begin
        errors++;
        $display("FAIL after_reset k=%0d: ena=%b busy=%b, want %b %b", k, ena, busy, (k == T_ON), (k < T_ON));
      end
    end
    go_idle();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_on_phase();
    test_sequence();
    test_abandon((T_ON > 5) ? 5 : 1, "abandon");
    test_abandon(T_ON, "collision");
    test_zero_target();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
